// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch
//   Receive-side 4-slot TDM demultiplexer. Aligns to a frame_sync marker on
//   slot 0 and distributes each accepted beat to one of four registered
//   channel outputs. It also produces per-channel strobes, a frame-complete
//   pulse, a lock indicator, an alignment-error pulse and a frame counter.
//
// Parameters
//   W       slot / channel data width
//   STRICT  1: a missing frame_sync at slot 0 while locked drops lock
//           0: free-run once locked (the beat is taken as slot 0)
//   CNT_W   width of the completed-frame counter (wraps)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   din         slot data beat
//   din_valid   din carries a slot this cycle
//   frame_sync  marks the current valid beat as slot 0
//   a,b,c,d     channel 0..3 data, registered, hold between updates
//   ch_valid    one-hot update strobe, bit i = channel i written
//   frame_done  pulse when slot 3 of an aligned frame is captured
//   locked      high while in the LOCKED state
//   sync_err    pulse on an alignment violation
//   frame_cnt   count of completed frames
module tdm_demux_4ch #(
  parameter int W      = 8,
  parameter bit STRICT = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  output logic [W-1:0]     c,
  output logic [W-1:0]     d,
  output logic [3:0]       ch_valid,
  output logic             frame_done,
  output logic             locked,
  output logic             sync_err,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t     state_p0, state_nxt;
  logic [1:0] slot_p0, slot_nxt;
  logic [3:0] wr_sel;
  logic       err_nxt;
  logic       done_nxt;

  // Stage p0: decode the incoming beat against the current alignment state
  always_comb begin
    state_nxt = state_p0;
    slot_nxt  = slot_p0;
    wr_sel    = 4'b0000;
    err_nxt   = 1'b0;
    done_nxt  = 1'b0;
    if (din_valid) begin
      case (state_p0)
        HUNT: begin
          if (frame_sync) begin
            wr_sel    = 4'b0001;
            slot_nxt  = 2'd1;
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // A marker always wins: realign on it, flagging a short frame.
            wr_sel   = 4'b0001;
            slot_nxt = 2'd1;
            err_nxt  = (slot_p0 != 2'd0);
          end else if (slot_p0 == 2'd0) begin
            if (STRICT) begin
              err_nxt   = 1'b1;
              slot_nxt  = 2'd0;
              state_nxt = HUNT;
            end else begin
              wr_sel   = 4'b0001;
              slot_nxt = 2'd1;
            end
          end else begin
            wr_sel   = 4'b0001 << slot_p0;
            slot_nxt = slot_p0 + 2'd1;
            done_nxt = (slot_p0 == 2'd3);
          end
        end
        default: begin
          state_nxt = HUNT;
          slot_nxt  = 2'd0;
        end
      endcase
    end
  end

  // Stage p1: registered control state and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0   <= HUNT;
      slot_p0    <= 2'd0;
      a          <= '0;
      b          <= '0;
      c          <= '0;
      d          <= '0;
      ch_valid   <= 4'b0000;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state_p0   <= state_nxt;
      slot_p0    <= slot_nxt;
      ch_valid   <= wr_sel;
      frame_done <= done_nxt;
      sync_err   <= err_nxt;
      if (wr_sel[0]) a <= din;
      if (wr_sel[1]) b <= din;
      if (wr_sel[2]) c <= din;
      if (wr_sel[3]) d <= din;
      if (done_nxt) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  assign locked = (state_p0 == LOCKED);

endmodule

// File: tb/tb_tdm_demux_4ch.sv
module tb_tdm_demux_4ch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;

  // u1: STRICT=1, CNT_W=16
  logic [7:0]  a1, b1, c1, d1;
  logic [3:0]  cv1;
  logic        fd1, lk1, se1;
  logic [15:0] cnt1;
  // u0: STRICT=0, CNT_W=16
  logic [7:0]  a0, b0, c0, d0;
  logic [3:0]  cv0;
  logic        fd0, lk0, se0;
  logic [15:0] cnt0;
  // u2: STRICT=1, CNT_W=2
  logic [7:0]  a2, b2, c2, d2;
  logic [3:0]  cv2;
  logic        fd2, lk2, se2;
  logic [1:0]  cnt2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tdm_demux_4ch #(.W(8), .STRICT(1'b1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .a(a1), .b(b1), .c(c1), .d(d1), .ch_valid(cv1), .frame_done(fd1),
    .locked(lk1), .sync_err(se1), .frame_cnt(cnt1));

  tdm_demux_4ch #(.W(8), .STRICT(1'b0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .a(a0), .b(b0), .c(c0), .d(d0), .ch_valid(cv0), .frame_done(fd0),
    .locked(lk0), .sync_err(se0), .frame_cnt(cnt0));

  tdm_demux_4ch #(.W(8), .STRICT(1'b1), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .a(a2), .b(b2), .c(c2), .d(d2), .ch_valid(cv2), .frame_done(fd2),
    .locked(lk2), .sync_err(se2), .frame_cnt(cnt2));

  // Drive one cycle of input, then sample 1 ns after the capturing edge.
  task automatic step(input logic v, input logic s, input logic [7:0] dat);
    din_valid  = v;
    frame_sync = s;
    din        = dat;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    din        = 8'h00;
    rst        = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({a1, b1, c1, d1} !== 32'h0 || {cv1, fd1, lk1, se1} !== 7'b0 || cnt1 !== 16'd0) begin
      miscompares++;
      $display("FAIL reset: abcd=%h cv=%b fd=%b lk=%b se=%b cnt=%0d want all zero",
               {a1, b1, c1, d1}, cv1, fd1, lk1, se1, cnt1);
    end
  endtask

  task automatic test_basic_frame();
    logic [7:0] dat [4];
    dat = '{8'h11, 8'h22, 8'h33, 8'h44};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i == 0), dat[i]);
      vectors++;
      if (cv1 !== (4'b0001 << i) || fd1 !== (i == 3) || lk1 !== 1'b1 || se1 !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_strobe[%0d]: cv=%b fd=%b lk=%b se=%b want cv=%b fd=%b lk=1 se=0",
                 i, cv1, fd1, lk1, se1, 4'b0001 << i, (i == 3));
      end
    end
    vectors++;
    if ({a1, b1, c1, d1} !== 32'h11223344 || cnt1 !== 16'd1) begin
      miscompares++;
      $display("FAIL basic_data: abcd=%h cnt=%0d want 11223344 cnt=1", {a1, b1, c1, d1}, cnt1);
    end
    step(1'b0, 1'b0, 8'h00);
    vectors++;
    if (cv1 !== 4'b0 || fd1 !== 1'b0 || {a1, b1, c1, d1} !== 32'h11223344) begin
      miscompares++;
      $display("FAIL basic_idle: cv=%b fd=%b abcd=%h want 0 0 11223344", cv1, fd1, {a1, b1, c1, d1});
    end
  endtask

  task automatic test_hunt();
    apply_reset();
    step(1'b1, 1'b0, 8'hAA);
    step(1'b1, 1'b0, 8'hBB);
    vectors++;
    if (cv1 !== 4'b0 || a1 !== 8'h00 || lk1 !== 1'b0) begin
      miscompares++;
      $display("FAIL hunt_discard: cv=%b a=%h lk=%b want 0 00 0", cv1, a1, lk1);
    end
    step(1'b1, 1'b1, 8'h01);
    vectors++;
    if (cv1 !== 4'b0001 || a1 !== 8'h01 || lk1 !== 1'b1) begin
      miscompares++;
      $display("FAIL hunt_lock: cv=%b a=%h lk=%b want 0001 01 1", cv1, a1, lk1);
    end
  endtask

  task automatic test_realign();
    apply_reset();
    step(1'b1, 1'b1, 8'h10);
    step(1'b1, 1'b0, 8'h20);
    step(1'b1, 1'b1, 8'h30);
    vectors++;
    if (se1 !== 1'b1 || a1 !== 8'h30 || b1 !== 8'h20 || cv1 !== 4'b0001 || fd1 !== 1'b0 || lk1 !== 1'b1) begin
      miscompares++;
      $display("FAIL realign_err: se=%b a=%h b=%h cv=%b fd=%b lk=%b want 1 30 20 0001 0 1",
               se1, a1, b1, cv1, fd1, lk1);
    end
    step(1'b1, 1'b0, 8'h40);
    step(1'b1, 1'b0, 8'h50);
    vectors++;
    if (se1 !== 1'b0 || fd1 !== 1'b0 || cnt1 !== 16'd0) begin
      miscompares++;
      $display("FAIL realign_mid: se=%b fd=%b cnt=%0d want 0 0 0", se1, fd1, cnt1);
    end
    step(1'b1, 1'b0, 8'h60);
    vectors++;
    if (fd1 !== 1'b1 || cv1 !== 4'b1000 || cnt1 !== 16'd1 || {a1, b1, c1, d1} !== 32'h30405060) begin
      miscompares++;
      $display("FAIL realign_frame: fd=%b cv=%b cnt=%0d abcd=%h want 1 1000 1 30405060",
               fd1, cv1, cnt1, {a1, b1, c1, d1});
    end
  endtask

  task automatic test_missing_sync();
    apply_reset();
    step(1'b1, 1'b1, 8'h01);
    step(1'b1, 1'b0, 8'h02);
    step(1'b1, 1'b0, 8'h03);
    step(1'b1, 1'b0, 8'h04);
    step(1'b1, 1'b0, 8'h55);
    vectors++;
    if (se1 !== 1'b1 || lk1 !== 1'b0 || a1 !== 8'h01 || cv1 !== 4'b0) begin
      miscompares++;
      $display("FAIL strict_drop: se=%b lk=%b a=%h cv=%b want 1 0 01 0000", se1, lk1, a1, cv1);
    end
    vectors++;
    if (se0 !== 1'b0 || lk0 !== 1'b1 || a0 !== 8'h55 || cv0 !== 4'b0001 || cnt0 !== 16'd1) begin
      miscompares++;
      $display("FAIL freerun_accept: se=%b lk=%b a=%h cv=%b cnt=%0d want 0 1 55 0001 1",
               se0, lk0, a0, cv0, cnt0);
    end
  endtask

  task automatic test_gapped();
    logic [7:0] got;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i % 4 == 0), 8'hA0 + 8'(i));
      case (i % 4)
        0: got = a1;
        1: got = b1;
        2: got = c1;
        default: got = d1;
      endcase
      vectors++;
      if (cv1 !== (4'b0001 << (i % 4)) || got !== 8'hA0 + 8'(i) || se1 !== 1'b0) begin
        miscompares++;
        $display("FAIL gapped_beat[%0d]: cv=%b data=%h se=%b want cv=%b data=%h se=0",
                 i, cv1, got, se1, 4'b0001 << (i % 4), 8'hA0 + 8'(i));
      end
      // frame_sync without din_valid must be ignored
      step(1'b0, 1'b1, 8'hFF);
      step(1'b0, 1'b0, 8'hEE);
      vectors++;
      if (cv1 !== 4'b0 || fd1 !== 1'b0 || se1 !== 1'b0 || got !== 8'hA0 + 8'(i)) begin
        miscompares++;
        $display("FAIL gapped_idle[%0d]: cv=%b fd=%b se=%b want 0 0 0", i, cv1, fd1, se1);
      end
    end
    vectors++;
    if (cnt1 !== 16'd2 || {a1, b1, c1, d1} !== 32'hA4A5A6A7) begin
      miscompares++;
      $display("FAIL gapped_total: cnt=%0d abcd=%h want 2 A4A5A6A7", cnt1, {a1, b1, c1, d1});
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    apply_reset();
    for (int f = 0; f < 5; f++) begin
      for (int s = 0; s < 4; s++) step(1'b1, (s == 0), 8'(16 * f + s));
      vectors++;
      if (cnt2 !== exp_cnt[f] || fd2 !== 1'b1) begin
        miscompares++;
        $display("FAIL cnt_wrap[%0d]: cnt=%0d fd=%b want %0d 1", f, cnt2, fd2, exp_cnt[f]);
      end
    end
    step(1'b1, 1'b1, 8'h61);
    step(1'b1, 1'b0, 8'h62);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({a2, b2, c2, d2} !== 32'h0 || {cv2, fd2, lk2, se2} !== 7'b0 || cnt2 !== 2'd0 || cnt1 !== 16'd0) begin
      miscompares++;
      $display("FAIL midframe_reset: abcd=%h cv=%b fd=%b lk=%b se=%b cnt=%0d want all zero",
               {a2, b2, c2, d2}, cv2, fd2, lk2, se2, cnt2);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b0, 8'h63);
    step(1'b1, 1'b0, 8'h64);
    vectors++;
    if (cv2 !== 4'b0 || fd2 !== 1'b0 || lk2 !== 1'b0 || {c2, d2} !== 16'h0) begin
      miscompares++;
      $display("FAIL post_reset_hunt: cv=%b fd=%b lk=%b cd=%h want 0 0 0 0000", cv2, fd2, lk2, {c2, d2});
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_hunt();
    test_realign();
    test_missing_sync();
    test_gapped();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tdm_demux_4ch.md
Name: tdm_demux_4ch

Overview:
Receive-side counterpart of the team's registered 4:1 channel mux. It takes a time-division-multiplexed stream of 4 slots per frame, aligns to a frame-sync marker, and distributes each beat into one of four registered channel outputs. Per-channel strobes, frame-complete, lock and error signals go to downstream consumers. It sits at the far end of a serial or shared link, where the transmitter rotates `sel` over channels a..d.

Parameters:
W, 8, data width of each slot and channel output
STRICT, 1, 1 = a missing frame_sync at slot 0 while locked drops lock; 0 = free-run once locked
CNT_W, 16, width of the completed-frame counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
din  input  W  slot data beat
din_valid  input  1  din carries a slot this cycle
frame_sync  input  1  qualifies the current valid beat as slot 0; ignored when din_valid=0
a  output  W  channel 0 data, registered, holds between updates
b  output  W  channel 1 data
c  output  W  channel 2 data
d  output  W  channel 3 data
ch_valid  output  4  one-cycle strobe; bit i high when channel i was updated
frame_done  output  1  one-cycle pulse when slot 3 of an aligned frame is captured
locked  output  1  high in LOCKED state
sync_err  output  1  one-cycle pulse on an alignment violation
frame_cnt  output  CNT_W  count of completed frames; wraps modulo 2^CNT_W

Behaviour:
- Reset (async assert, deassert sampled at clk): a=b=c=d=0, ch_valid=0, frame_done=0, sync_err=0, frame_cnt=0, locked=0, state=HUNT, slot=0.
- All outputs are registered. Latency is 1 cycle: a beat sampled at edge N appears on its channel output and strobe after edge N.
- Internal 2-bit slot counter. It advances only on accepted beats and wraps 3 -> 0.
- HUNT:
  - Valid beats with frame_sync=0 are discarded. No strobes.
  - A valid beat with frame_sync=1 writes din to a, pulses ch_valid[0], sets slot=1 and moves to LOCKED.
- LOCKED, on each valid beat:
  - frame_sync=1 with slot=0: normal. Write a, pulse ch_valid[0], slot=1.
  - frame_sync=1 with slot!=0: pulse sync_err and realign. The beat is treated as slot 0: write a, pulse ch_valid[0], slot=1. The partial frame yields no frame_done. Stay LOCKED.
  - frame_sync=0 with slot=0, STRICT=1: pulse sync_err, discard the beat, go to HUNT, locked=0.
  - frame_sync=0 with slot=0, STRICT=0: accept the beat as slot 0.
  - frame_sync=0 with slot in 1..3: write the channel selected by slot (1=b, 2=c, 3=d), pulse ch_valid[slot] and increment slot.
  - slot=3 accepted: also pulse frame_done and increment frame_cnt, same cycle as ch_valid[3].
- din_valid=0: no state change. Strobes deassert and outputs hold.
- ch_valid is one-hot or zero, never multi-bit.
- frame_done implies ch_valid[3] in the same cycle.
- Reset mid-frame: everything returns to reset values immediately. The partial frame is lost and no pulses are emitted.

Test Plan:
1. Reset, then valid beats 0x11(sync),0x22,0x33,0x44 -> a=11,b=22,c=33,d=44; ch_valid 1,2,4,8 on consecutive cycles; frame_done with the 0x44 strobe; frame_cnt=1; locked=1 after the first beat.
2. In HUNT, beats 0xAA,0xBB without sync, then 0x01(sync) -> the first two produce no strobes and a=0; a=01, locked=1 after the third.
3. Locked, after 0x10(sync),0x20 send 0x30 with sync -> sync_err pulse; a=30; b stays 20; no frame_done; the next 3 beats complete a frame, frame_cnt increments by 1.
4. STRICT=1: full frame, then a slot-0 beat 0x55 without sync -> sync_err, locked=0, a unchanged. STRICT=0: same stimulus gives a=55, ch_valid[0], no error.
5. Gapped din_valid (valid every 3rd cycle) over 2 frames -> outputs hold between beats; frame_cnt=2; no spurious strobes. frame_sync asserted while din_valid=0 is ignored.
6. CNT_W=2: 5 frames -> frame_cnt sequence 1,2,3,0,1. Assert rst between the b and c beats -> all outputs 0 immediately, HUNT, no frame_done.
